// File: rtl/rgb_ycbcr_csc_pipe.sv
// RGB to YCbCr colour-space converter: 4-stage pipeline (multiply, partial add,
// final add, round/clamp) with frame-synchronous mode switching and clip reporting.
module rgb_ycbcr_csc_pipe #(
  parameter int WD_IMG_DATA = 8,
  parameter int WD_ERR_INFO = 4,
  parameter int MD_SIM_ABLE = 0
) (
  input  logic                   i_sys_clk,
  input  logic                   i_sys_reset,
  input  logic [1:0]             i_cfg_mode,
  input  logic                   s_img_rgb_c_fsync,
  input  logic                   s_img_rgb_c_vsync,
  input  logic                   s_img_rgb_c_hsync,
  input  logic                   s_img_rgb_c_valid,
  input  logic [WD_IMG_DATA-1:0] s_img_rgb_r_mdat0,
  input  logic [WD_IMG_DATA-1:0] s_img_rgb_g_mdat1,
  input  logic [WD_IMG_DATA-1:0] s_img_rgb_b_mdat2,
  output logic                   m_img_ycbcr_c_fsync,
  output logic                   m_img_ycbcr_c_vsync,
  output logic                   m_img_ycbcr_c_hsync,
  output logic                   m_img_ycbcr_c_valid,
  output logic [WD_IMG_DATA-1:0] m_img_ycbcr_y_mdat0,
  output logic [WD_IMG_DATA-1:0] m_img_ycbcr_b_mdat1,
  output logic [WD_IMG_DATA-1:0] m_img_ycbcr_r_mdat2,
  output logic [WD_ERR_INFO-1:0] m_err_info
);

  localparam int SW = WD_IMG_DATA + 12;
  typedef logic signed [SW-1:0] sum_t;

  // Bypass is expressed as unity (256/256) coefficients, so it needs no separate datapath.
  localparam logic signed [9:0] COEF [4][3][3] = '{
    '{'{10'sd76, 10'sd150, 10'sd29}, '{-10'sd43, -10'sd84, 10'sd128}, '{10'sd128, -10'sd107, -10'sd20}},
    '{'{10'sd66, 10'sd129, 10'sd25}, '{-10'sd38, -10'sd74, 10'sd112}, '{10'sd112, -10'sd94, -10'sd18}},
    '{'{10'sd47, 10'sd157, 10'sd16}, '{-10'sd26, -10'sd87, 10'sd112}, '{10'sd112, -10'sd102, -10'sd10}},
    '{'{10'sd0, 10'sd256, 10'sd0}, '{10'sd0, 10'sd0, 10'sd256}, '{10'sd256, 10'sd0, 10'sd0}}
  };

  localparam sum_t MAX_PIX = sum_t'((1 << WD_IMG_DATA) - 1);
  localparam sum_t OFS_16  = sum_t'(16 << WD_IMG_DATA);
  localparam sum_t OFS_128 = sum_t'(128 << WD_IMG_DATA);
  localparam sum_t RND     = sum_t'(128);
  localparam sum_t ZERO    = sum_t'(0);

  function automatic sum_t offset_of(input logic [1:0] mode, input int comp);
    sum_t ofs;
    if (mode == 2'd3) begin
      ofs = ZERO;
    end else if (comp != 0) begin
      ofs = OFS_128;
    end else if (mode == 2'd0) begin
      ofs = ZERO;
    end else begin
      ofs = OFS_16;
    end
    return ofs;
  endfunction

  logic [1:0]             mode_r;
  logic [1:0]             mode_s;
  logic [WD_IMG_DATA-1:0] pix_s [3];
  logic [3:0]             ctl_s;
  logic [3:0]             ctl_r [4];
  sum_t                   prod_r [3][3];
  sum_t                   ofs_r [3];
  sum_t                   part_a_r [3];
  sum_t                   part_b_r [3];
  sum_t                   sum_r [3];
  sum_t                   shift_s [3];
  logic [WD_IMG_DATA-1:0] clamp_s [3];
  logic [2:0]             clip_s;
  logic [WD_IMG_DATA-1:0] out_r [3];
  logic [2:0]             sticky_r;

  if (MD_SIM_ABLE != 0) begin : g_sim_hooks
  end

  // A frame-start pixel already uses the mode requested on its own cycle.
  always_comb begin
    mode_s   = s_img_rgb_c_fsync ? i_cfg_mode : mode_r;
    pix_s[0] = s_img_rgb_r_mdat0;
    pix_s[1] = s_img_rgb_g_mdat1;
    pix_s[2] = s_img_rgb_b_mdat2;
    ctl_s    = {s_img_rgb_c_fsync, s_img_rgb_c_vsync, s_img_rgb_c_hsync, s_img_rgb_c_valid};
  end

  // Stage 1: mode register, coefficient products and per-component offset.
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_reset) begin
      mode_r <= 2'd0;
      for (int c = 0; c < 3; c++) begin
        ofs_r[c] <= ZERO;
        for (int k = 0; k < 3; k++) prod_r[c][k] <= ZERO;
      end
    end else begin
      if (s_img_rgb_c_fsync) mode_r <= i_cfg_mode;
      for (int c = 0; c < 3; c++) begin
        ofs_r[c] <= offset_of(mode_s, c);
        for (int k = 0; k < 3; k++)
          prod_r[c][k] <= sum_t'($signed({1'b0, pix_s[k]})) * sum_t'(COEF[mode_s][c][k]);
      end
    end
  end

  // Stages 2 and 3: partial sums, then full sum including offset and rounding term.
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_reset) begin
      for (int c = 0; c < 3; c++) begin
        part_a_r[c] <= ZERO;
        part_b_r[c] <= ZERO;
        sum_r[c]    <= ZERO;
      end
    end else begin
      for (int c = 0; c < 3; c++) begin
        part_a_r[c] <= prod_r[c][0] + prod_r[c][1];
        part_b_r[c] <= prod_r[c][2] + ofs_r[c] + RND;
        sum_r[c]    <= part_a_r[c] + part_b_r[c];
      end
    end
  end

  // Stage 4 combinational part: scale back and clamp to the pixel range.
  always_comb begin
    for (int c = 0; c < 3; c++) begin
      shift_s[c] = sum_r[c] >>> 8;
      if (shift_s[c] < ZERO) begin
        clamp_s[c] = '0;
        clip_s[c]  = 1'b1;
      end else if (shift_s[c] > MAX_PIX) begin
        clamp_s[c] = '1;
        clip_s[c]  = 1'b1;
      end else begin
        clamp_s[c] = shift_s[c][WD_IMG_DATA-1:0];
        clip_s[c]  = 1'b0;
      end
    end
  end

  // Control pipeline, output data and sticky clip flags (frame start wins over history).
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_reset) begin
      for (int s = 0; s < 4; s++) ctl_r[s] <= 4'b0000;
      for (int c = 0; c < 3; c++) out_r[c] <= '0;
      sticky_r <= 3'b000;
    end else begin
      ctl_r[0] <= ctl_s;
      for (int s = 1; s < 4; s++) ctl_r[s] <= ctl_r[s-1];
      for (int c = 0; c < 3; c++) out_r[c] <= clamp_s[c];
      sticky_r <= (ctl_r[2][3] ? 3'b000 : sticky_r) | (ctl_r[2][0] ? clip_s : 3'b000);
    end
  end

  // Output mapping; the pending-mode bit is deliberately combinational.
  always_comb begin
    {m_img_ycbcr_c_fsync, m_img_ycbcr_c_vsync, m_img_ycbcr_c_hsync, m_img_ycbcr_c_valid} = ctl_r[3];
    m_img_ycbcr_y_mdat0 = out_r[0];
    m_img_ycbcr_b_mdat1 = out_r[1];
    m_img_ycbcr_r_mdat2 = out_r[2];
    m_err_info          = '0;
    m_err_info[2:0]     = sticky_r;
    m_err_info[3]       = (i_cfg_mode != mode_r);
  end

endmodule

// File: tb/tb_rgb_ycbcr_csc_pipe.sv
// Self-checking bench for rgb_ycbcr_csc_pipe: directed table, corner sequences,
// and randomized traffic checked against an arithmetic reference model.
module tb_rgb_ycbcr_csc_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] cfg;
  logic       fs, vs, hs, vld;
  logic [7:0] r, g, b;
  logic       o_fs, o_vs, o_hs, o_vld;
  logic [7:0] o_y, o_cb, o_cr;
  logic [3:0] err;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  rgb_ycbcr_csc_pipe #(.WD_IMG_DATA(8), .WD_ERR_INFO(4), .MD_SIM_ABLE(0)) dut (
    .i_sys_clk(clk), .i_sys_reset(rst), .i_cfg_mode(cfg),
    .s_img_rgb_c_fsync(fs), .s_img_rgb_c_vsync(vs), .s_img_rgb_c_hsync(hs), .s_img_rgb_c_valid(vld),
    .s_img_rgb_r_mdat0(r), .s_img_rgb_g_mdat1(g), .s_img_rgb_b_mdat2(b),
    .m_img_ycbcr_c_fsync(o_fs), .m_img_ycbcr_c_vsync(o_vs), .m_img_ycbcr_c_hsync(o_hs),
    .m_img_ycbcr_c_valid(o_vld),
    .m_img_ycbcr_y_mdat0(o_y), .m_img_ycbcr_b_mdat1(o_cb), .m_img_ycbcr_r_mdat2(o_cr),
    .m_err_info(err)
  );

  typedef struct {
    logic [3:0] ctl;
    int         y, cb, cr;
    logic [2:0] clip;
  } exp_t;

  typedef struct {
    int         mode, r, g, b, y, cb, cr;
    logic [2:0] clip;
  } vec_t;

  exp_t       pipe_q[$];
  exp_t       zero_e;
  int         act_mode;
  logic [2:0] sticky_m;
  bit         armed = 1'b0;
  vec_t       tbl[7];

  function automatic int clamp8(input int v, output logic c);
    if (v < 0) begin
      c = 1'b1;
      return 0;
    end else if (v > 255) begin
      c = 1'b1;
      return 255;
    end else begin
      c = 1'b0;
      return v;
    end
  endfunction

  function automatic exp_t model(input int mode, input int rr, input int gg, input int bb,
                                 input logic [3:0] ctl);
    exp_t e;
    int   k[3][3];
    int   oy;
    logic c0, c1, c2;
    e.ctl = ctl;
    if (mode == 3) begin
      e.y = gg; e.cb = bb; e.cr = rr; e.clip = 3'b000;
      return e;
    end
    case (mode)
      0:       begin k = '{'{76, 150, 29}, '{-43, -84, 128}, '{128, -107, -20}}; oy = 0;  end
      1:       begin k = '{'{66, 129, 25}, '{-38, -74, 112}, '{112, -94, -18}};  oy = 16; end
      default: begin k = '{'{47, 157, 16}, '{-26, -87, 112}, '{112, -102, -10}}; oy = 16; end
    endcase
    e.y  = clamp8((k[0][0]*rr + k[0][1]*gg + k[0][2]*bb + oy*256  + 128) >>> 8, c0);
    e.cb = clamp8((k[1][0]*rr + k[1][1]*gg + k[1][2]*bb + 128*256 + 128) >>> 8, c1);
    e.cr = clamp8((k[2][0]*rr + k[2][1]*gg + k[2][2]*bb + 128*256 + 128) >>> 8, c2);
    e.clip = {c2, c1, c0};
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  // One clock edge: advance the reference model and compare every output.
  task automatic tick();
    exp_t e;
    int   m;
    @(posedge clk);
    #1;
    if (rst) begin
      pipe_q.delete();
      repeat (3) pipe_q.push_back(zero_e);
      act_mode = 0;
      sticky_m = 3'b000;
      armed    = 1'b1;
      e        = zero_e;
    end else begin
      m = fs ? int'(cfg) : act_mode;
      pipe_q.push_back(model(m, int'(r), int'(g), int'(b), {fs, vs, hs, vld}));
      if (fs) act_mode = int'(cfg);
      e = pipe_q.pop_front();
    end
    if (armed) begin
      sticky_m = (e.ctl[3] ? 3'b000 : sticky_m) | (e.ctl[0] ? e.clip : 3'b000);
      chk("ctl", {o_fs, o_vs, o_hs, o_vld}, e.ctl);
      chk("y", o_y, e.y);
      chk("cb", o_cb, e.cb);
      chk("cr", o_cr, e.cr);
      chk("err", err, {int'(cfg) != act_mode, sticky_m});
    end
  endtask

  task automatic drive(input logic f, input logic v, input int rr, input int gg, input int bb);
    fs = f; vld = v; r = 8'(rr); g = 8'(gg); b = 8'(bb);
  endtask

  initial begin
    zero_e = '{ctl: 4'b0000, y: 0, cb: 0, cr: 0, clip: 3'b000};
    tbl[0] = '{mode: 0, r: 0,   g: 0,   b: 0,   y: 0,   cb: 128, cr: 128, clip: 3'b000};
    tbl[1] = '{mode: 0, r: 255, g: 255, b: 255, y: 254, cb: 129, cr: 129, clip: 3'b000};
    tbl[2] = '{mode: 2, r: 255, g: 0,   b: 0,   y: 63,  cb: 102, cr: 240, clip: 3'b000};
    tbl[3] = '{mode: 0, r: 0,   g: 0,   b: 255, y: 29,  cb: 255, cr: 108, clip: 3'b010};
    tbl[4] = '{mode: 0, r: 255, g: 0,   b: 0,   y: 76,  cb: 85,  cr: 255, clip: 3'b100};
    tbl[5] = '{mode: 1, r: 255, g: 255, b: 255, y: 235, cb: 128, cr: 128, clip: 3'b000};
    tbl[6] = '{mode: 3, r: 10,  g: 20,  b: 30,  y: 20,  cb: 30,  cr: 10,  clip: 3'b000};

    rst = 1'b1; cfg = 2'd0; vs = 1'b0; hs = 1'b0;
    drive(1'b0, 1'b0, 0, 0, 0);
    tick(); tick();
    rst = 1'b0;
    repeat (4) tick();

    // Directed table: each vector is a frame-start pixel followed by idle cycles.
    for (int i = 0; i < 7; i++) begin
      cfg = 2'(tbl[i].mode);
      drive(1'b1, 1'b1, tbl[i].r, tbl[i].g, tbl[i].b);
      tick();
      drive(1'b0, 1'b0, 0, 0, 0);
      repeat (3) tick();
      chk("tbl_valid", o_vld, 1);
      chk("tbl_y", o_y, tbl[i].y);
      chk("tbl_cb", o_cb, tbl[i].cb);
      chk("tbl_cr", o_cr, tbl[i].cr);
      chk("tbl_err", err, {1'b0, tbl[i].clip});
    end

    // Sticky Cb clip held across a frame, cleared by the next output frame start.
    cfg = 2'd0;
    drive(1'b1, 1'b1, 0, 0, 255);
    tick();
    drive(1'b0, 1'b1, 0, 0, 0);
    repeat (5) tick();
    chk("sticky_hold", err, 4'b0010);
    drive(1'b1, 1'b1, 0, 0, 0);
    tick();
    drive(1'b0, 1'b0, 0, 0, 0);
    repeat (3) tick();
    chk("sticky_clear", err, 4'b0000);

    // Mode change mid-frame waits for the next input frame start.
    cfg = 2'd2;
    drive(1'b0, 1'b1, 255, 0, 0);
    tick();
    chk("pending_set", err[3], 1);
    repeat (3) tick();
    chk("old_mode_y", o_y, 76);
    drive(1'b1, 1'b1, 255, 0, 0);
    tick();
    chk("pending_clear", err[3], 0);
    drive(1'b0, 1'b1, 255, 0, 0);
    repeat (3) tick();
    chk("new_mode_y", o_y, 63);
    chk("new_mode_cr", o_cr, 240);

    // Reset mid-line with three pixels in flight.
    cfg = 2'd0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 40 + i, 90, 200);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_outs", {o_fs, o_vs, o_hs, o_vld, o_y, o_cb, o_cr, err}, 0);
    drive(1'b0, 1'b0, 0, 0, 0);
    repeat (3) tick();
    chk("rst_no_valid", o_vld, 0);
    drive(1'b0, 1'b1, 12, 34, 56);
    tick();
    drive(1'b0, 1'b0, 0, 0, 0);
    repeat (3) tick();
    chk("rst_first_valid", o_vld, 1);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 7) == 0) cfg = 2'($urandom_range(0, 3));
      rst = ($urandom_range(0, 499) == 0);
      vs  = 1'($urandom_range(0, 1));
      hs  = 1'($urandom_range(0, 1));
      drive(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
            $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
